// File: rtl/quad_pkg.sv
// Shared types and helpers for the quadrature decoder: phase states, edge
// classes and the Gray-code neighbour relations used to classify transitions.
package quad_pkg;

    typedef enum logic [2:0] {UNSYNC, P00, P01, P11, P10} phase_t;
    typedef enum logic [1:0] {NONE, CW, CCW, ILLEGAL} edge_t;

    localparam logic DIR_CW  = 1'b1;
    localparam logic DIR_CCW = 1'b0;

    function automatic phase_t phase_of(input logic [1:0] ab);
        phase_t p;
        case (ab)
            2'b00:   p = P00;
            2'b01:   p = P01;
            2'b11:   p = P11;
            default: p = P10;
        endcase
        return p;
    endfunction

    function automatic logic [1:0] ab_of(input phase_t p);
        logic [1:0] ab;
        case (p)
            P01:     ab = 2'b01;
            P11:     ab = 2'b11;
            P10:     ab = 2'b10;
            default: ab = 2'b00;
        endcase
        return ab;
    endfunction

    // CW successor of {a,b} is {b,~a}; CCW successor is {~b,a}.
    function automatic edge_t classify(input phase_t cur, input logic [1:0] ab);
        logic [1:0] cur_ab;
        edge_t      e;
        cur_ab = ab_of(cur);
        if (cur == UNSYNC || ab == cur_ab)
            e = NONE;
        else if (ab == {cur_ab[0], ~cur_ab[1]})
            e = CW;
        else if (ab == {~cur_ab[0], cur_ab[1]})
            e = CCW;
        else
            e = ILLEGAL;
        return e;
    endfunction

endpackage

// File: rtl/quad_pos_counter.sv
// Position register stepped by single-cycle inc/dec requests; either wraps
// modulo 2^WIDTH or saturates at the range bounds.
module quad_pos_counter #(
    parameter int WIDTH = 8,
    parameter int WRAP  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             dec,
    input  logic             clr,
    output logic [WIDTH-1:0] pos
);

    localparam logic [WIDTH-1:0] POS_MAX = '1;
    localparam logic [WIDTH-1:0] POS_MIN = '0;

    logic [WIDTH-1:0] pos_reg;
    logic [WIDTH-1:0] pos_next;

    generate
        if (WRAP != 0) begin : g_wrap
            always_comb begin
                pos_next = pos_reg;
                if (clr)
                    pos_next = '0;
                else if (inc)
                    pos_next = pos_reg + 1'b1;
                else if (dec)
                    pos_next = pos_reg - 1'b1;
            end
        end else begin : g_sat
            always_comb begin
                pos_next = pos_reg;
                if (clr)
                    pos_next = '0;
                else if (inc && pos_reg != POS_MAX)
                    pos_next = pos_reg + 1'b1;
                else if (dec && pos_reg != POS_MIN)
                    pos_next = pos_reg - 1'b1;
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            pos_reg <= '0;
        else
            pos_reg <= pos_next;
    end

    assign pos = pos_reg;

endmodule

// File: rtl/quad_decoder.sv
// Quadrature decoder: registers A/B, tracks the Gray-code phase, accumulates
// valid edges into detent steps and drives the position counter.
module quad_decoder #(
    parameter int WIDTH = 8,
    parameter int DIV   = 4,
    parameter int WRAP  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a,
    input  logic             b,
    input  logic             en,
    input  logic             clr,
    input  logic             err_clr,
    output logic [WIDTH-1:0] pos,
    output logic             step,
    output logic             dir,
    output logic             err
);

    import quad_pkg::*;

    localparam logic signed [3:0] DIV_POS = 4'(DIV);
    localparam logic signed [3:0] DIV_NEG = -DIV_POS;

    logic [1:0]        ab_reg;
    phase_t            phase_reg;
    logic signed [2:0] acc_reg;
    logic              step_reg;
    logic              dir_reg;
    logic              err_reg;

    edge_t             edge_type;
    logic signed [3:0] acc_sum;
    logic              is_move;
    logic              hit_cw;
    logic              hit_ccw;
    logic              inc;
    logic              dec;

    // The sum is one bit wider than acc_reg so that +DIV (=4) is representable.
    always_comb begin
        edge_type = classify(phase_reg, ab_reg);
        is_move   = (edge_type == CW) || (edge_type == CCW);
        acc_sum   = {acc_reg[2], acc_reg};
        if (edge_type == CW)
            acc_sum = acc_sum + 4'sd1;
        else if (edge_type == CCW)
            acc_sum = acc_sum - 4'sd1;
        hit_cw  = en && (edge_type == CW)  && (acc_sum == DIV_POS);
        hit_ccw = en && (edge_type == CCW) && (acc_sum == DIV_NEG);
        inc     = hit_cw  && !clr;
        dec     = hit_ccw && !clr;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ab_reg    <= 2'b00;
            phase_reg <= UNSYNC;
            acc_reg   <= '0;
            step_reg  <= 1'b0;
            dir_reg   <= DIR_CCW;
            err_reg   <= 1'b0;
        end else begin
            ab_reg <= {a, b};
            // Sync from the sample being captured so the stale reset value of
            // ab_reg can never be mistaken for a phase jump.
            if (phase_reg == UNSYNC)
                phase_reg <= phase_of({a, b});
            else
                phase_reg <= phase_of(ab_reg);

            if (edge_type == ILLEGAL)
                err_reg <= 1'b1;
            else if (err_clr)
                err_reg <= 1'b0;

            step_reg <= inc || dec;
            if (inc)
                dir_reg <= DIR_CW;
            else if (dec)
                dir_reg <= DIR_CCW;

            if (clr)
                acc_reg <= '0;
            else if (en && is_move)
                acc_reg <= (hit_cw || hit_ccw) ? 3'sd0 : acc_sum[2:0];
        end
    end

    quad_pos_counter #(
        .WIDTH (WIDTH),
        .WRAP  (WRAP)
    ) u_pos_counter (
        .clk (clk),
        .rst (rst),
        .inc (inc),
        .dec (dec),
        .clr (clr),
        .pos (pos)
    );

    assign step = step_reg;
    assign dir  = dir_reg;
    assign err  = err_reg;

endmodule

// File: tb/tb_quad_decoder.sv
// Directed bench for quad_decoder: a wrapping and a saturating instance share
// stimulus; expectations come from a transaction-level model via a queue.
module tb_quad_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic       a, b, en, clr, err_clr;
    logic [7:0] pos, pos_s;
    logic       step, step_s, dir, dir_s, err, err_s;

    always #5 clk = ~clk;

    quad_decoder #(.WIDTH(8), .DIV(4), .WRAP(1)) u_dut (
        .clk(clk), .rst(rst), .a(a), .b(b), .en(en), .clr(clr), .err_clr(err_clr),
        .pos(pos), .step(step), .dir(dir), .err(err)
    );

    quad_decoder #(.WIDTH(8), .DIV(4), .WRAP(0)) u_dut_sat (
        .clk(clk), .rst(rst), .a(a), .b(b), .en(en), .clr(clr), .err_clr(err_clr),
        .pos(pos_s), .step(step_s), .dir(dir_s), .err(err_s)
    );

    typedef struct {
        string      tag;
        logic [7:0] pos;
        logic [7:0] pos_s;
        logic       dir;
        logic       err;
    } exp_t;

    exp_t sb[$];

    int checks = 0;
    int errors = 0;

    logic [1:0] m_ab;
    int         m_acc;
    logic [7:0] m_pos, m_pos_s;
    logic       m_dir, m_err, m_en;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int idx(input logic [1:0] ab);
        case (ab)
            2'b00:   return 0;
            2'b01:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    // Drive one phase and hold it 4 clocks; step must appear exactly 2 clocks
    // after the change. clr_mid raises clr on the cycle that processes it.
    task automatic apply(input logic [1:0] ab, input string tag, input bit clr_mid = 1'b0);
        int   d;
        bit   exp_step;
        exp_t e;
        d        = (idx(ab) - idx(m_ab) + 4) % 4;
        exp_step = 1'b0;
        if (d == 2) begin
            m_err = 1'b1;
        end else if (d != 0 && m_en) begin
            m_acc += (d == 1) ? 1 : -1;
            if (m_acc == 4 || m_acc == -4) begin
                if (!clr_mid) begin
                    exp_step = 1'b1;
                    m_dir    = (m_acc > 0);
                    if (m_acc > 0) begin
                        m_pos = m_pos + 8'd1;
                        if (m_pos_s != 8'hFF) m_pos_s = m_pos_s + 8'd1;
                    end else begin
                        m_pos = m_pos - 8'd1;
                        if (m_pos_s != 8'h00) m_pos_s = m_pos_s - 8'd1;
                    end
                end
                m_acc = 0;
            end
        end
        if (clr_mid) begin
            m_acc   = 0;
            m_pos   = 8'h00;
            m_pos_s = 8'h00;
        end
        m_ab = ab;
        e = '{tag, m_pos, m_pos_s, m_dir, m_err};
        sb.push_back(e);

        {a, b} = ab;
        tick();
        chk($sformatf("%s/step_early", tag), 32'(step), 32'd0);
        if (clr_mid) clr = 1'b1;
        tick();
        clr = 1'b0;
        chk($sformatf("%s/step", tag), 32'(step), 32'(exp_step));
        chk($sformatf("%s/step_sat", tag), 32'(step_s), 32'(exp_step));
        tick();
        chk($sformatf("%s/step_late", tag), 32'(step), 32'd0);
        tick();

        e = sb.pop_front();
        $display("txn %-12s ab=%b pos=%0d pos_sat=%0d dir=%b err=%b step_exp=%b",
                 e.tag, ab, pos, pos_s, dir, err, exp_step);
        chk($sformatf("%s/pos", e.tag), 32'(pos), 32'(e.pos));
        chk($sformatf("%s/pos_sat", e.tag), 32'(pos_s), 32'(e.pos_s));
        chk($sformatf("%s/dir", e.tag), 32'(dir), 32'(e.dir));
        chk($sformatf("%s/err", e.tag), 32'(err), 32'(e.err));
    endtask

    task automatic clr_pulse(input string tag);
        clr = 1'b1;
        tick();
        clr     = 1'b0;
        m_pos   = 8'h00;
        m_pos_s = 8'h00;
        m_acc   = 0;
        chk($sformatf("%s/pos", tag), 32'(pos), 32'(m_pos));
        chk($sformatf("%s/pos_sat", tag), 32'(pos_s), 32'(m_pos_s));
    endtask

    task automatic err_clr_pulse(input string tag);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        m_err   = 1'b0;
        chk($sformatf("%s/err", tag), 32'(err), 32'(m_err));
        chk($sformatf("%s/err_sat", tag), 32'(err_s), 32'(m_err));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; a = 1'b1; b = 1'b1; en = 1'b1; clr = 1'b0; err_clr = 1'b0;
        m_ab = 2'b11; m_acc = 0; m_pos = 8'h00; m_pos_s = 8'h00;
        m_dir = 1'b0; m_err = 1'b0; m_en = 1'b1;
        repeat (2) tick();
        rst = 1'b0;

        // Reset sync with a=b=1: no step, no error
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("sync/step", 32'(step), 32'd0);
        end
        chk("sync/pos", 32'(pos), 32'd0);
        chk("sync/err", 32'(err), 32'd0);
        chk("sync/dir", 32'(dir), 32'd0);

        // Walk back to 00, then discard the partial detent
        apply(2'b10, "pre1");
        apply(2'b00, "pre2");
        clr_pulse("pre_clr");

        // Four CW detents
        for (int k = 0; k < 4; k++) begin
            apply(2'b01, $sformatf("cw%0d_a", k));
            apply(2'b11, $sformatf("cw%0d_b", k));
            apply(2'b10, $sformatf("cw%0d_c", k));
            apply(2'b00, $sformatf("cw%0d_d", k));
        end

        // CCW detent from 0: wrap to 255, saturate at 0
        clr_pulse("ccw_clr");
        apply(2'b10, "ccw_a");
        apply(2'b11, "ccw_b");
        apply(2'b01, "ccw_c");
        apply(2'b00, "ccw_d");

        // Reversal inside a detent
        apply(2'b01, "rev_a");
        apply(2'b11, "rev_b");
        apply(2'b01, "rev_c");
        apply(2'b00, "rev_d");

        // Illegal jump then a clean CW detent
        apply(2'b11, "illegal");
        apply(2'b10, "post_a");
        apply(2'b00, "post_b");
        apply(2'b01, "post_c");
        apply(2'b11, "post_d");
        err_clr_pulse("err_clr");

        // clr coincident with the step-completing edge
        apply(2'b10, "cs_a");
        apply(2'b00, "cs_b");
        apply(2'b01, "cs_c");
        apply(2'b11, "cs_d", 1'b1);

        // en=0: eight CW edges do not count
        en = 1'b0; m_en = 1'b0;
        for (int k = 0; k < 2; k++) begin
            apply(2'b10, "dis_a");
            apply(2'b00, "dis_b");
            apply(2'b01, "dis_c");
            apply(2'b11, "dis_d");
        end
        en = 1'b1; m_en = 1'b1;
        apply(2'b10, "ena_a");
        apply(2'b00, "ena_b");
        apply(2'b01, "ena_c");
        apply(2'b11, "ena_d");

        // Raise err, then asynchronous reset mid-cycle
        apply(2'b00, "pre_rst");
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("arst/pos", 32'(pos), 32'd0);
        chk("arst/pos_sat", 32'(pos_s), 32'd0);
        chk("arst/dir", 32'(dir), 32'd0);
        chk("arst/err", 32'(err), 32'd0);
        chk("arst/step", 32'(step), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        m_acc = 0; m_pos = 8'h00; m_pos_s = 8'h00; m_dir = 1'b0; m_err = 1'b0;
        m_ab = {a, b};
        repeat (3) tick();
        chk("resync/err", 32'(err), 32'd0);
        apply(2'b01, "resync_a");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
